apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 124 ++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the requester FSM state encoding.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time, runs the SETUP/ACCESS handshake on the
// APB bus and returns a single response (read data, slave error, timeout) to the consumer.
//
// Ports
//   PCLK, PRESET           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_write/cmd_addr/cmd_wdata describe it
//   rsp_valid/rsp_ready    response handshake; rsp_rdata/rsp_err/rsp_timeout carry it
//   busy                   high whenever the FSM is not idle
//   PSEL..PWDATA           APB requester outputs
//   PRDATA/PREADY/PSLVERR  APB completer inputs
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Counter is wide enough to hold TIMEOUT; a disabled timeout still gets one bit.
  localparam int unsigned CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TmoLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [CntW-1:0] TmoLastCnt = TmoLast[CntW-1:0];
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  apb_state_e      state_q;
  logic [CntW-1:0] wait_cnt_q;

  // Decoded straight from the state register so acceptance never depends on inputs.
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state_q <= StSetup;
          end
        end

        StSetup: begin
          PENABLE    <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StAccess;
        end

        StAccess: begin
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            state_q     <= StResp;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == TmoLastCnt)) begin
            // Completer never answered: abandon the transfer with an error response.
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state_q     <= StResp;
          end else if (wait_cnt_q != CntMax) begin
            wait_cnt_q <= wait_cnt_q + CntOne;
          end
        end

        StResp: begin
          // rsp_* hold their values until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
